reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port register file and successor to the single-write, dual-read file in the pipelined RV32I core. It adds the following:
- Configurable width, depth and port counts.
- Asynchronous clear of all registers.
- Multi-write-port priority and write-through bypass on every read port.
- A per-register pending scoreboard, so the issue stage can detect outstanding producers without a separate hazard unit.

It sits between decode/issue and writeback.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
NUM_RD, 2, read ports (1..4)
NUM_WR, 1, write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  read data, combinational
rd_pend  out  NUM_RD  1 = addressed register still awaits an in-flight producer
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_WIDTH  write addresses
wr_data  in  NUM_WR*DATA_WIDTH  write data
iss_en  in  1  mark iss_addr pending (instruction with destination issued)
iss_addr  in  ADDR_WIDTH  destination being issued
flush  in  1  synchronous clear of all pending bits (pipeline flush)

Behaviour:
- Reset (rst high, asynchronous):
  - All registers and all pending bits clear to 0 immediately.
  - rd_data and rd_pend therefore read 0 during reset.
  - Writes and issues are ignored while rst is high.
  - Deassertion takes effect on the next rising edge of clk.
- Write (synchronous, rising edge):
  - Each port with wr_en=1 writes wr_data to wr_addr.
  - If two ports target the same address in one cycle, the higher-index port wins.
  - Address 0 is never written when ZERO_REG=1.
- Read (combinational). For each port p:
  - If ZERO_REG=1 and rd_addr=0, rd_data=0 and rd_pend=0.
  - Otherwise, if any write port w has wr_en=1 and wr_addr == rd_addr, rd_data = wr_data of the highest such w (write-through bypass, zero added latency).
  - Otherwise rd_data = stored register.
- Scoreboard: one pending bit per register, updated on the rising edge.
  - Priority is flush > issue set > write clear.
  - flush=1: all bits clear, and iss_en is ignored that cycle.
  - iss_en=1: bit[iss_addr] is set (not for address 0 when ZERO_REG=1).
  - Any wr_en with matching address clears the bit, unless iss_en targets the same address in the same cycle. In that case the bit stays set, because the new producer supersedes the old one.
  - Issuing to an already-pending register keeps it set; there is no counter, and last issuer wins.
- rd_pend[p] = pending[rd_addr_p] AND NOT (any wr_en with wr_addr == rd_addr_p).
  - A value being written back this cycle is reported as available, since the bypass supplies it.
  - Same-cycle iss_en does not affect rd_pend; the issuing instruction sees the state before issue.
- Latencies:
  - Write to stored value: 1 cycle.
  - Write to read data: 0 cycles (bypass).
  - Issue to rd_pend=1: next cycle.
  - Writeback to rd_pend=0: same cycle.
- No X propagation: all storage is reset, and out-of-range addresses are impossible because depth = 2**ADDR_WIDTH.

Test Plan:
1. Bypass and write: default params. Write x5=0xDEADBEEF; in the same cycle rd_addr0=5 -> rd_data0=0xDEADBEEF that cycle; after the edge with wr_en=0 -> still 0xDEADBEEF.
2. Zero register: write x0=0x1234 and iss_en to x0 -> reading x0 gives 0 with rd_pend=0 during and after the write.
3. Dual-write conflict: NUM_WR=2; both ports write x7, port0=0x11 and port1=0x22 -> bypass shows 0x22, and after the edge x7 stores 0x22.
4. Scoreboard lifecycle: iss_en x3 -> next cycle rd_pend=1 for x3. Write x3=0x55 -> rd_pend=0 that cycle and data 0x55. After the edge, pending stays 0.
5. Issue/write collision: x9 is pending; in one cycle, write x9=0x1 with iss_en x9 -> after the edge rd_pend for x9 = 1.
6. Flush and reset: set several pending bits; flush -> all rd_pend=0 next cycle. Then write x4=0x77 and assert rst asynchronously mid-cycle -> rd_data for x4=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with write-through bypass on every read
// port and a per-register pending scoreboard for issue-stage hazard detection.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_pend,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  input  logic                           flush
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;

  logic [NUM_WR-1:0]     wr_act;
  logic [ADDR_WIDTH-1:0] wr_a   [NUM_WR];
  logic [DATA_WIDTH-1:0] wr_d   [NUM_WR];
  logic [ADDR_WIDTH-1:0] rd_a   [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_word[NUM_RD];
  logic [NUM_RD-1:0]     rd_hit;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return HAS_ZERO && (a == '0);
  endfunction

  // Writes are suppressed during reset so the bypass also reads back zero.
  assign wr_act = wr_en & {NUM_WR{~rst}};

  // Unpack flat port buses into per-port views.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wr_a[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      wr_d[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_a[p] = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Register next state; ascending port order lets the higher-index port win.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_act[w] && !is_zero(wr_a[w])) begin
        regs_d[wr_a[w]] = wr_d[w];
      end
    end
  end

  // Scoreboard next state: write clear, then issue set, then flush override.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_act[w]) begin
        pend_d[wr_a[w]] = 1'b0;
      end
    end
    if (iss_en && !is_zero(iss_addr)) begin
      pend_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q <= pend_d;
    end
  end

  // Read ports: zero register, then highest matching write port, then storage.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_word[p] = regs_q[rd_a[p]];
      rd_hit[p]  = 1'b0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_act[w] && (wr_a[w] == rd_a[p])) begin
          rd_hit[p]  = 1'b1;
          rd_word[p] = wr_d[w];
        end
      end
      if (!is_zero(rd_a[p])) begin
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_word[p];
        rd_pend[p]                          = pend_q[rd_a[p]] & ~rd_hit[p];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios followed by random
// traffic, all compared against an array-based behavioural model.
module tb_reg_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_pend;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mdl_regs [32];
  logic          mdl_pend [32];

  reg_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
    wr_en[w]            = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  // Expected read result from the model state plus this cycle's writes.
  task automatic compare_reads();
    for (int p = 0; p < int'(NR); p++) begin
      int            a;
      logic [DW-1:0] ed;
      logic          ep;
      a  = int'(rd_addr[p*AW +: AW]);
      ed = mdl_regs[a];
      ep = mdl_pend[a];
      for (int w = 0; w < int'(NW); w++) begin
        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
          ed = wr_data[w*DW +: DW];
          ep = 1'b0;
        end
      end
      if (a == 0 || rst) begin
        ed = '0;
        ep = 1'b0;
      end
      chk_eq($sformatf("rd%0d_data@x%0d", p, a), rd_data[p*DW +: DW], ed);
      chk_eq($sformatf("rd%0d_pend@x%0d", p, a), 32'(rd_pend[p]), 32'(ep));
    end
  endtask

  // Clock-edge state change of the model, straight from the behavioural rules.
  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        mdl_regs[r] = '0;
        mdl_pend[r] = 1'b0;
      end
    end else begin
      bit written [32];
      for (int w = 0; w < int'(NW); w++) begin
        if (wr_en[w]) begin
          int a;
          a = int'(wr_addr[w*AW +: AW]);
          written[a] = 1'b1;
          if (a != 0) mdl_regs[a] = wr_data[w*DW +: DW];
        end
      end
      for (int r = 1; r < 32; r++) begin
        if (flush)                                 mdl_pend[r] = 1'b0;
        else if (iss_en && int'(iss_addr) == r)    mdl_pend[r] = 1'b1;
        else if (written[r])                       mdl_pend[r] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_reads();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      mdl_regs[r] = '0;
      mdl_pend[r] = 1'b0;
    end
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    idle();
    #1 rst = 1'b1;
    set_rd(0, 5);
    set_rd(1, 9);
    #1;
    chk_eq("reset_data", rd_data[31:0], 32'h0);
    chk_eq("reset_pend", 32'(rd_pend), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Bypass then stored value
    set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5);
    #1 chk_eq("t1_bypass", rd_data[31:0], 32'hDEADBEEF);
    cycle(); idle();
    #1 chk_eq("t1_stored", rd_data[31:0], 32'hDEADBEEF);
    cycle();

    // Zero register ignores write and issue
    set_wr(0, 0, 32'h1234); set_iss(0); set_rd(0, 0);
    #1 chk_eq("t2_data_dur", rd_data[31:0], 32'h0);
    chk_eq("t2_pend_dur", 32'(rd_pend[0]), 32'h0);
    cycle(); idle();
    #1 chk_eq("t2_data_aft", rd_data[31:0], 32'h0);
    chk_eq("t2_pend_aft", 32'(rd_pend[0]), 32'h0);
    cycle();

    // Dual-write conflict: port 1 wins
    set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(1, 7);
    #1 chk_eq("t3_bypass", rd_data[63:32], 32'h22);
    cycle(); idle();
    #1 chk_eq("t3_stored", rd_data[63:32], 32'h22);
    cycle();

    // Scoreboard lifecycle
    set_iss(3); set_rd(0, 3);
    #1 chk_eq("t4_pend_same", 32'(rd_pend[0]), 32'h0);
    cycle(); idle();
    #1 chk_eq("t4_pend_next", 32'(rd_pend[0]), 32'h1);
    set_wr(0, 3, 32'h55);
    #1 chk_eq("t4_pend_wb", 32'(rd_pend[0]), 32'h0);
    chk_eq("t4_data_wb", rd_data[31:0], 32'h55);
    cycle(); idle();
    #1 chk_eq("t4_pend_aft", 32'(rd_pend[0]), 32'h0);
    cycle();

    // Issue/write collision keeps the bit set
    set_iss(9); cycle(); idle();
    set_rd(0, 9); set_wr(0, 9, 32'h1); set_iss(9);
    #1 chk_eq("t5_pend_same", 32'(rd_pend[0]), 32'h0);
    cycle(); idle();
    #1 chk_eq("t5_pend_aft", 32'(rd_pend[0]), 32'h1);
    cycle();

    // Flush clears everything and wins over a same-cycle issue
    set_iss(10); cycle();
    set_iss(11); cycle(); idle();
    set_rd(0, 10); set_rd(1, 11);
    #1 chk_eq("t6_pend10", 32'(rd_pend[0]), 32'h1);
    chk_eq("t6_pend11", 32'(rd_pend[1]), 32'h1);
    flush = 1'b1; set_iss(13);
    cycle(); idle();
    #1 chk_eq("t6_fl_pend10", 32'(rd_pend[0]), 32'h0);
    chk_eq("t6_fl_pend11", 32'(rd_pend[1]), 32'h0);
    set_rd(1, 13);
    #1 chk_eq("t6_fl_pend13", 32'(rd_pend[1]), 32'h0);
    cycle();

    // Asynchronous reset mid-cycle
    set_wr(0, 4, 32'h77); cycle(); idle(); set_rd(0, 4);
    #1 chk_eq("t6_stored4", rd_data[31:0], 32'h77);
    set_wr(0, 4, 32'h99);
    #2 rst = 1'b1;
    #1 chk_eq("t6_async_rst", rd_data[31:0], 32'h0);
    cycle();
    rst = 1'b0; idle();
    cycle();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      idle();
      rst = ($urandom_range(0, 79) == 0);
      for (int w = 0; w < int'(NW); w++) begin
        if ($urandom_range(0, 2) == 0) set_wr(w, int'($urandom_range(0, 11)), $urandom());
      end
      if ($urandom_range(0, 2) == 0) set_iss(int'($urandom_range(0, 11)));
      flush = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < int'(NR); p++) set_rd(p, int'($urandom_range(0, 11)));
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
